// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/write sequencer with a per-stage watchdog that parks the core in ERROR.
// Optional SEQ_PERF_COUNTERS_EN adds busy-cycle and retired-instruction counters.
module stage_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  output logic        fetch_enabled,
  input  logic        fetch_completed,
  output logic        decode_enabled,
  input  logic        decode_completed,
  output logic        exec_enabled,
  input  logic        exec_completed,
  output logic        mem_enabled,
  input  logic        mem_completed,
  output logic        write_enabled,
  input  logic        write_completed,
  input  logic        is_load,
  input  logic        is_store,
  output logic        busy,
  output logic        instr_retired,
  output logic [2:0]  stage,
  output logic        timeout_err
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, F_ISS, F_WT, D_ISS, D_WT, E_ISS, E_WT, M_ISS, M_WT, W_ISS, W_WT, ERROR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wd_cnt;
  logic              wd_trip;
  logic              in_wait;
  logic              mem_needed;

  assign in_wait = state_q inside {F_WT, D_WT, E_WT, M_WT, W_WT};
  // wd_cnt holds (wait cycles so far - 1), so this flags the last allowed wait cycle
  assign wd_trip = (TIMEOUT_CYCLES != 0) && (wd_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wd_cnt      <= '0;
      mem_needed  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_wait) wd_cnt <= wd_cnt + 1'b1;
      else         wd_cnt <= '0;
      if (state_q == D_WT && decode_completed) mem_needed <= is_load | is_store;
      if (state_d == ERROR) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (run) state_d = F_ISS;
      F_ISS: state_d = F_WT;
      F_WT:  if (fetch_completed) state_d = D_ISS;
             else if (wd_trip)    state_d = ERROR;
      D_ISS: state_d = D_WT;
      D_WT:  if (decode_completed) state_d = E_ISS;
             else if (wd_trip)     state_d = ERROR;
      E_ISS: state_d = E_WT;
      E_WT:  if (exec_completed) state_d = mem_needed ? M_ISS : W_ISS;
             else if (wd_trip)   state_d = ERROR;
      M_ISS: state_d = M_WT;
      M_WT:  if (mem_completed) state_d = W_ISS;
             else if (wd_trip)  state_d = ERROR;
      W_ISS: state_d = W_WT;
      W_WT:  if (write_completed) state_d = run ? F_ISS : IDLE;
             else if (wd_trip)    state_d = ERROR;
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  assign fetch_enabled  = (state_q == F_ISS);
  assign decode_enabled = (state_q == D_ISS);
  assign exec_enabled   = (state_q == E_ISS);
  assign mem_enabled    = (state_q == M_ISS);
  assign write_enabled  = (state_q == W_ISS);
  assign busy           = (state_q != IDLE) && (state_q != ERROR);
  assign instr_retired  = (state_q == W_WT) && write_completed;

  always_comb begin
    stage = 3'd0;
    case (state_q)
      F_ISS, F_WT: stage = 3'd1;
      D_ISS, D_WT: stage = 3'd2;
      E_ISS, E_WT: stage = 3'd3;
      M_ISS, M_WT: stage = 3'd4;
      W_ISS, W_WT: stage = 3'd5;
      ERROR:       stage = 3'd7;
      default:     stage = 3'd0;
    endcase
  end

`ifdef SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (busy)          cycle_count   <= cycle_count + 32'd1;
      if (instr_retired) retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: per-cycle outputs checked against a schedule computed from stage delays.
module tb_stage_sequencer;

  localparam int TO   = 6;
  localparam int NEXP = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic run = 1'b0;
  logic fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled;
  logic fetch_completed = 1'b0, decode_completed = 1'b0, exec_completed = 1'b0;
  logic mem_completed = 1'b0, write_completed = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0;
  logic busy, instr_retired, timeout_err;
  logic [2:0] stage;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count, retired_count;
`endif

  stage_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(3)) u_dut (
    .clk(clk), .rstn(rstn), .run(run),
    .fetch_enabled(fetch_enabled),   .fetch_completed(fetch_completed),
    .decode_enabled(decode_enabled), .decode_completed(decode_completed),
    .exec_enabled(exec_enabled),     .exec_completed(exec_completed),
    .mem_enabled(mem_enabled),       .mem_completed(mem_completed),
    .write_enabled(write_enabled),   .write_completed(write_completed),
    .is_load(is_load), .is_store(is_store),
    .busy(busy), .instr_retired(instr_retired), .stage(stage), .timeout_err(timeout_err)
`ifdef SEQ_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          dly [64][5];
  logic        ld [64];
  logic        st [64];
  logic [10:0] exp_arr [NEXP];
  logic        run_arr [NEXP];
  int          ncyc;
  int          fcount = 0;
  int          w [5];
  int          dcur [5];
  logic [4:0]  comp = '0;
  logic [4:0]  stuck = '0;
  logic        hold = 1'b0;
  logic [10:0] obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [10:0] mk(input logic te, input logic [4:0] en, input logic r,
                                     input logic b, input logic [2:0] s);
    return {te, en, r, b, s};
  endfunction

  function automatic logic [10:0] sample();
    return {timeout_err, write_enabled, mem_enabled, exec_enabled, decode_enabled, fetch_enabled,
            instr_retired, busy, stage};
  endfunction

  // Stage models: completed stays low for dly cycles after the enable cycle, then rises.
  task automatic respond();
    logic [4:0] en;
    int cur;
    en = {write_enabled, mem_enabled, exec_enabled, decode_enabled, fetch_enabled};
    if (en[0]) fcount++;
    cur = (fcount > 0) ? fcount - 1 : 0;
    for (int s = 0; s < 5; s++) begin
      if (en[s]) begin
        w[s] = 0;
        dcur[s] = dly[cur][s];
      end else if (w[s] < 1000) begin
        w[s]++;
      end
      comp[s] = !stuck[s] && (w[s] > dcur[s]);
    end
    {write_completed, mem_completed, exec_completed, decode_completed, fetch_completed} = comp;
    if (en[1]) hold = 1'b1;
    else if (en[2]) hold = 1'b0;
    if (hold) begin
      is_load  = ld[cur];
      is_store = st[cur];
    end else begin
      is_load  = 1'($urandom_range(0, 1));
      is_store = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
    #1;
    obs = sample();
  endtask

  initial begin
    int c, ni, g, n, exp_busy, exp_ret;
    logic seen;
    for (int s = 0; s < 5; s++) begin w[s] = 0; dcur[s] = 0; end
    for (int i = 0; i < 64; i++) begin
      ld[i] = 1'b0; st[i] = 1'b0;
      for (int s = 0; s < 5; s++) dly[i][s] = 0;
    end

    // Build the expected per-cycle schedule from random stage delays.
    c = 0; ni = 0;
    for (int b = 0; b < 4; b++) begin
      g = $urandom_range(1, 4);
      for (int k = 0; k < g; k++) begin
        exp_arr[c] = mk(1'b0, 5'b0, 1'b0, 1'b0, 3'd0);
        run_arr[c] = (k == g - 1);
        c++;
      end
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        ld[ni] = 1'($urandom_range(0, 1));
        st[ni] = 1'($urandom_range(0, 1));
        for (int s = 0; s < 5; s++)
          dly[ni][s] = ($urandom_range(0, 6) == 0) ? TO - 1 : int'($urandom_range(0, 3));
        for (int s = 0; s < 5; s++) begin
          if (s == 3 && !(ld[ni] | st[ni])) continue;
          exp_arr[c] = mk(1'b0, 5'(1 << s), 1'b0, 1'b1, 3'(s + 1));
          run_arr[c] = 1'($urandom_range(0, 1));
          c++;
          for (int k = 0; k <= dly[ni][s]; k++) begin
            exp_arr[c] = mk(1'b0, 5'b0, (s == 4) && (k == dly[ni][s]), 1'b1, 3'(s + 1));
            run_arr[c] = 1'($urandom_range(0, 1));
            c++;
          end
        end
        run_arr[c - 1] = (j != n - 1);
        ni++;
      end
    end
    ncyc = c;
    exp_busy = 0; exp_ret = 0;
    for (int k = 0; k < ncyc; k++) begin
      exp_busy += int'(exp_arr[k][3]);
      exp_ret  += int'(exp_arr[k][4]);
    end

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset", 32'(sample()), 32'(mk(1'b0, 5'b0, 1'b0, 1'b0, 3'd0)));
`ifdef SEQ_PERF_COUNTERS_EN
    check_eq("reset_cycle_count", cycle_count, 32'd0);
    check_eq("reset_retired_count", retired_count, 32'd0);
`endif
    rstn = 1'b1;

    for (int k = 0; k < ncyc; k++) begin
      tick();
      check_eq($sformatf("cyc%0d", k), 32'(obs), 32'(exp_arr[k]));
      run = run_arr[k];
    end
    tick();
    run = 1'b0;
    check_eq("idle_after_burst", 32'(obs), 32'(mk(1'b0, 5'b0, 1'b0, 1'b0, 3'd0)));
`ifdef SEQ_PERF_COUNTERS_EN
    check_eq("cycle_count", cycle_count, 32'(exp_busy));
    check_eq("retired_count", retired_count, 32'(exp_ret));
`endif

    // Memory stage hangs: watchdog must trip after TO wait cycles.
    for (int s = 0; s < 5; s++) dly[fcount][s] = 0;
    ld[fcount] = 1'b0; st[fcount] = 1'b1;
    stuck = 5'b01000;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      run = 1'b1;
      if (obs[8]) seen = 1'b1;
    end
    check_eq("mem_enable_seen", 32'(seen), 32'd1);
    for (int k = 1; k <= TO; k++) tick();
    check_eq("last_wait_cycle", 32'(obs), 32'(mk(1'b0, 5'b0, 1'b0, 1'b1, 3'd4)));
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq($sformatf("error%0d", k), 32'(obs), 32'(mk(1'b1, 5'b0, 1'b0, 1'b0, 3'd7)));
    end
    rstn = 1'b0;
    #1;
    check_eq("reset_from_error", 32'(sample()), 32'(mk(1'b0, 5'b0, 1'b0, 1'b0, 3'd0)));
    stuck = 5'b0;
    tick();
    rstn = 1'b1;

    // Reset asserted while decode is still working.
    for (int s = 0; s < 5; s++) dly[fcount][s] = 0;
    dly[fcount][1] = 3;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      run = 1'b1;
      if (obs[6]) seen = 1'b1;
    end
    check_eq("decode_enable_seen", 32'(seen), 32'd1);
    tick();
    check_eq("decode_wait", 32'(obs), 32'(mk(1'b0, 5'b0, 1'b0, 1'b1, 3'd2)));
    rstn = 1'b0;
    #1;
    check_eq("reset_in_dwt", 32'(sample()), 32'(mk(1'b0, 5'b0, 1'b0, 1'b0, 3'd0)));
`ifdef SEQ_PERF_COUNTERS_EN
    check_eq("reset_in_dwt_cycle_count", cycle_count, 32'd0);
    check_eq("reset_in_dwt_retired_count", retired_count, 32'd0);
`endif
    run = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    check_eq("idle_final", 32'(obs), 32'(mk(1'b0, 5'b0, 1'b0, 1'b0, 3'd0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM for the non-pipelined core. It walks each instruction through fetch, decode, exec, mem and write by pulsing each stage's `enabled` input and waiting for that stage's `completed`. The mem stage is skipped for instructions the decoder does not flag as load or store. A per-stage watchdog catches a hung stage and parks the core in an error state.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: wait-state cycles before the watchdog trips; 0 disables the watchdog.
- `TO_W`, default 11: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `run`  in  1  level; 1 = keep issuing instructions.
- `fetch_enabled` / `fetch_completed`  out/in  1/1  fetch stage handshake.
- `decode_enabled` / `decode_completed`  out/in  1/1  decoder handshake.
- `exec_enabled` / `exec_completed`  out/in  1/1  exec stage handshake.
- `mem_enabled` / `mem_completed`  out/in  1/1  memory stage handshake.
- `write_enabled` / `write_completed`  out/in  1/1  writeback handshake.
- `is_load`  in  1  decoded instruction is a load; registered decoder output, valid once decode completes.
- `is_store`  in  1  decoded instruction is a store; same validity as `is_load`.
- `busy`  out  1  1 in any state other than IDLE and ERROR.
- `instr_retired`  out  1  one-cycle pulse when writeback completes.
- `stage`  out  3  current stage: 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 write, 7 error.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, then for each stage X in {F, D, E, M, W} an issue state X_ISS and a wait state X_WT, then ERROR.
- IDLE: if `run`=1, go to F_ISS; otherwise stay.
- X_ISS: lasts exactly one cycle; the matching `X_enabled`=1 for that cycle only; then go to X_WT.
- X_WT: `X_enabled`=0. `X_completed` is sampled only here. When it is 1, advance:
  - F to D_ISS.
  - D to E_ISS; on this edge register `mem_needed` = `is_load` | `is_store`.
  - E to M_ISS if `mem_needed`, else W_ISS.
  - M to W_ISS.
  - W: pulse `instr_retired`; go to F_ISS if `run`=1, else IDLE.
- Stage contract: `completed` may stay high from an earlier instruction only if the stage's results are final at the end of its enable cycle. A multi-cycle stage must drive `completed`=0 from the cycle after `enabled` until it is done.
- `run` is sampled only in IDLE and at the W_WT exit; dropping it mid-instruction lets that instruction finish.
- Outputs are registered, driven from the state register; there are no combinational paths from inputs to `*_enabled`.
- Watchdog: counter cleared on entry to every X_WT and incremented each cycle the state stays there. On reaching TIMEOUT_CYCLES without completion, go to ERROR and set `timeout_err`=1.
- ERROR: all enables 0, `busy`=0, `stage`=7. Only `rstn` leaves ERROR.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE.
  - all `*_enabled`, `busy`, `instr_retired`, `timeout_err` = 0; `stage`=0.
  - `mem_needed` = 0; watchdog counter = 0.
- Reset mid-instruction aborts immediately; no partial `instr_retired`.
- Stage whose `completed` is high in the cycle after enable: 2 cycles per stage.
- Instruction latency, F_ISS entry to the `instr_retired` cycle inclusive:
  - non-memory instruction: 8 cycles.
  - load or store: 10 cycles.
- Back-to-back with `run`=1: F_ISS directly follows the retire cycle, so the period is 8 or 10 cycles.
- From IDLE with `run`=1: F_ISS is entered on the next edge.
- `instr_retired` is high in the W_WT cycle that sees `write_completed`=1.
- Watchdog: ERROR is entered on the edge after the TIMEOUT_CYCLES-th wait cycle. A completion arriving in that same cycle wins: advance, no error.

## Configuration
- `SEQ_PERF_COUNTERS_EN` defined adds two outputs:
  - `cycle_count` (out, 32): counts every cycle with `busy`=1.
  - `retired_count` (out, 32): increments on `instr_retired`.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- `run`=1, all stages complete 1 cycle after enable, `is_load`=`is_store`=0 → `fetch_enabled` pulses every 8 cycles, `mem_enabled` never asserts, `instr_retired` period 8.
- Decode reports `is_store`=1 → `mem_enabled` pulses once, 2 cycles after `exec_enabled`; retire at cycle 10.
- Exec holds `exec_completed`=0 for 5 cycles after enable → `stage`=3 held; the next enable follows 1 cycle after completion; retire at cycle 13.
- `TIMEOUT_CYCLES`=4, `mem_completed` stuck 0 → ERROR after 4 wait cycles; `timeout_err`=1, `busy`=0, no enables until `rstn` is pulsed.
- `run` dropped during exec → the instruction retires, then state is IDLE and no further `fetch_enabled`. `rstn` asserted during D_WT → all outputs 0 at once, `stage`=0.
- With `SEQ_PERF_COUNTERS_EN`: 3 non-memory instructions then IDLE → `retired_count`=3, `cycle_count`=24.
